// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared rv32 trap CSR constants and types
// used by the machine-mode trap sequencer
package trap_ctrl_pkg;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MSTATUS  = 12'h300;
  localparam csr_addr_t CSR_MIE      = 12'h304;
  localparam csr_addr_t CSR_MTVEC    = 12'h305;
  localparam csr_addr_t CSR_MSTATUSH = 12'h310;
  localparam csr_addr_t CSR_MEPC     = 12'h341;
  localparam csr_addr_t CSR_MCAUSE   = 12'h342;
  localparam csr_addr_t CSR_MTVAL    = 12'h343;
  localparam csr_addr_t CSR_MIP      = 12'h344;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;
  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int PEND_MSI = 0;
  localparam int PEND_MTI = 1;
  localparam int PEND_MEI = 2;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1
  } mtvec_mode_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SLEEP    = 2'd2
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// trap_irq_prio: fixed-priority pick among enabled
// pending interrupts, MEI > MSI > MTI
module trap_irq_prio
  import trap_ctrl_pkg::*;
(
  input  logic [2:0] irq_pend,
  output logic       valid,
  output logic [3:0] cause
);

  // Highest-priority pending source wins
  always_comb begin
    valid = 1'b1;
    cause = IRQ_MEI;
    priority case (1'b1)
      irq_pend[PEND_MEI]: cause = IRQ_MEI;
      irq_pend[PEND_MSI]: cause = IRQ_MSI;
      irq_pend[PEND_MTI]: cause = IRQ_MTI;
      default: begin
        valid = 1'b0;
        cause = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap CSRs, interrupt/exception
// arbitration, trap entry, mret and wfi sequencing
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_tval,
  input  logic        mret,
  input  logic        wfi,
  input  logic        irq_mei,
  input  logic        irq_msi,
  input  logic        irq_mti,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        stall
);

  localparam logic [31:0] MTVEC_WMASK =
    VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  trap_state_e state_q, state_d;

  logic        st_mie, st_mpie;
  logic [2:0]  mip_q;
  logic [31:0] mie_q, mtvec_q, mepc_q;
  logic [31:0] mcause_q, mtval_q;
  logic [31:0] wfi_pc_q, redir_pc_q;

  logic [2:0]  pend;
  logic        irq_valid;
  logic [3:0]  irq_cause;
  logic        take_irq, take_exc;
  logic        do_mret, do_wfi, csr_wr;
  logic [31:0] trap_pc, vec_base, trap_vec;

  assign pend[PEND_MEI] = mip_q[PEND_MEI] & mie_q[MIE_MEIE];
  assign pend[PEND_MSI] = mip_q[PEND_MSI] & mie_q[MIE_MSIE];
  assign pend[PEND_MTI] = mip_q[PEND_MTI] & mie_q[MIE_MTIE];

  trap_irq_prio u_prio (
    .irq_pend (pend),
    .valid    (irq_valid),
    .cause    (irq_cause)
  );

  assign vec_base = {mtvec_q[31:2], 2'b00};
  assign trap_vec =
    (take_irq &&
     mtvec_mode_e'(mtvec_q[1:0]) == MTVEC_VECTORED)
    ? vec_base + {26'd0, irq_cause, 2'b00}
    : vec_base;
  assign csr_wr = csr_we & ~(take_irq | take_exc);

  // Next state, trap arbitration and redirect outputs
  always_comb begin
    state_d        = state_q;
    take_irq       = 1'b0;
    take_exc       = 1'b0;
    do_mret        = 1'b0;
    do_wfi         = 1'b0;
    trap_pc        = commit_pc;
    redirect_valid = (state_q == ST_REDIRECT);
    flush          = (state_q == ST_REDIRECT);
    stall          = (state_q == ST_SLEEP);
    redirect_pc    = redir_pc_q;
    unique case (state_q)
      ST_RUN: begin
        if (commit_valid) begin
          if (st_mie && irq_valid) take_irq = 1'b1;
          else if (exc_valid)      take_exc = 1'b1;
          else if (mret)           do_mret  = 1'b1;
          else if (wfi)            do_wfi   = 1'b1;
        end
      end
      ST_SLEEP: begin
        if (irq_valid) begin
          if (st_mie) begin
            take_irq = 1'b1;
            trap_pc  = wfi_pc_q + 32'd4;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
    if (take_irq || take_exc || do_mret)
      state_d = ST_REDIRECT;
    else if (do_wfi)
      state_d = ST_SLEEP;
  end

  // CSR state; trap entry and mret override CSR writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mip_q      <= '0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC & MTVEC_WMASK;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      wfi_pc_q   <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q <= state_d;
      mip_q   <= {irq_mei, irq_mti, irq_msi};
      if (csr_wr) begin
        unique case (1'b1)
          (csr_addr == CSR_MSTATUS): begin
            st_mie  <= csr_wdata[MSTATUS_MIE];
            st_mpie <= csr_wdata[MSTATUS_MPIE];
          end
          (csr_addr == CSR_MIE):
            mie_q <= csr_wdata & MIE_WMASK;
          (csr_addr == CSR_MTVEC):
            mtvec_q <= csr_wdata & MTVEC_WMASK;
          (csr_addr == CSR_MEPC):
            mepc_q <= csr_wdata & 32'hFFFF_FFFC;
          (csr_addr == CSR_MCAUSE):
            mcause_q <= csr_wdata;
          (csr_addr == CSR_MTVAL):
            mtval_q <= csr_wdata;
          default: ;
        endcase
      end
      if (take_irq || take_exc) begin
        st_mpie    <= st_mie;
        st_mie     <= 1'b0;
        mepc_q     <= trap_pc;
        redir_pc_q <= trap_vec;
        mcause_q   <= take_irq
                      ? {1'b1, 27'd0, irq_cause}
                      : {28'd0, exc_code};
        mtval_q    <= take_irq ? 32'd0 : exc_tval;
      end
      if (do_mret) begin
        st_mie     <= st_mpie;
        st_mpie    <= 1'b1;
        redir_pc_q <= mepc_q;
      end
      if (do_wfi)
        wfi_pc_q <= commit_pc;
    end
  end

  // Combinational CSR read mux
  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b1;
    unique case (1'b1)
      (csr_addr == CSR_MSTATUS): begin
        csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        csr_rdata[MSTATUS_MPIE] = st_mpie;
        csr_rdata[MSTATUS_MIE]  = st_mie;
      end
      (csr_addr == CSR_MSTATUSH): csr_rdata = '0;
      (csr_addr == CSR_MIE):      csr_rdata = mie_q;
      (csr_addr == CSR_MTVEC):    csr_rdata = mtvec_q;
      (csr_addr == CSR_MEPC):     csr_rdata = mepc_q;
      (csr_addr == CSR_MCAUSE):   csr_rdata = mcause_q;
      (csr_addr == CSR_MTVAL):    csr_rdata = mtval_q;
      (csr_addr == CSR_MIP): begin
        csr_rdata[MIP_MEIP] = mip_q[PEND_MEI];
        csr_rdata[MIP_MSIP] = mip_q[PEND_MSI];
        csr_rdata[MIP_MTIP] = mip_q[PEND_MTI];
      end
      default: csr_hit = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of
// trap_ctrl against a behavioural trap model
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_tval;
  logic        mret, wfi;
  logic        irq_mei, irq_msi, irq_mti;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall;

  int passed = 0;
  int total  = 0;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSTATUSH = 12'h310;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;

  trap_ctrl #(
    .RESET_MTVEC (32'h0000_0000),
    .VECTORED_EN (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_tval       (exc_tval),
    .mret           (mret),
    .wfi            (wfi),
    .irq_mei        (irq_mei),
    .irq_msi        (irq_msi),
    .irq_mti        (irq_mti),
    .csr_addr       (csr_addr),
    .csr_we         (csr_we),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_hit        (csr_hit),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic chk_csr(input string tag,
                         input logic [11:0] a,
                         input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a,
                    input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_we    = 1'b1;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc,
                        input logic        ex,
                        input logic [3:0]  code,
                        input logic [31:0] tv,
                        input logic        m,
                        input logic        w);
    commit_pc    = pc;
    exc_valid    = ex;
    exc_code     = code;
    exc_tval     = tv;
    mret         = m;
    wfi          = w;
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    exc_valid    = 1'b0;
    mret         = 1'b0;
    wfi          = 1'b0;
  endtask

  // reference model state for the randomized phase
  logic        m_mie, m_mpie, trapped;
  logic [31:0] m_ie, m_tvec, m_epc, m_cause, m_tval;
  logic [31:0] w, pc, tv, base, exp_pc;
  logic [2:0]  lines;
  logic        ex;
  logic [3:0]  code;
  int          cause, n;

  initial begin
    rst_n = 1'b0;
    commit_valid = 1'b0; commit_pc = '0;
    exc_valid = 1'b0; exc_code = '0; exc_tval = '0;
    mret = 1'b0; wfi = 1'b0;
    irq_mei = 1'b0; irq_msi = 1'b0; irq_mti = 1'b0;
    csr_addr = '0; csr_we = 1'b0; csr_wdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk_csr("rst_mtvec", A_MTVEC, 32'h0);
    chk_csr("rst_mstatus", A_MSTATUS, 32'h1800);
    chk_csr("rst_mcause", A_MCAUSE, 32'h0);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // synchronous exception
    wr(A_MTVEC, 32'h100);
    commit(32'h40, 1'b1, 4'd2, 32'hDEAD, 1'b0, 1'b0);
    chk("exc_redir_v", {31'd0, redirect_valid}, 32'd1);
    chk("exc_flush", {31'd0, flush}, 32'd1);
    chk("exc_redir_pc", redirect_pc, 32'h100);
    tick();
    chk("exc_pulse", {31'd0, redirect_valid}, 32'd0);
    chk_csr("exc_mepc", A_MEPC, 32'h40);
    chk_csr("exc_mcause", A_MCAUSE, 32'h2);
    chk_csr("exc_mtval", A_MTVAL, 32'hDEAD);
    chk_csr("exc_mstatus", A_MSTATUS, 32'h1800);

    // vectored interrupt, MEI beats MTI
    wr(A_MTVEC, 32'h201);
    wr(A_MIE, 32'h888);
    wr(A_MSTATUS, 32'h8);
    irq_mti = 1'b1;
    irq_mei = 1'b1;
    tick();
    chk_csr("irq_mip", A_MIP, 32'h880);
    commit(32'h80, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    chk("irq_redir_v", {31'd0, redirect_valid}, 32'd1);
    chk("irq_redir_pc", redirect_pc, 32'h22C);
    tick();
    chk_csr("irq_mcause", A_MCAUSE, 32'h8000000B);
    chk_csr("irq_mepc", A_MEPC, 32'h80);
    chk_csr("irq_mtval", A_MTVAL, 32'h0);
    chk_csr("irq_mstatus", A_MSTATUS, 32'h1880);

    // mret back to mepc
    wr(A_MEPC, 32'h47);
    chk_csr("mepc_mask", A_MEPC, 32'h44);
    commit(32'h50, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
    irq_mti = 1'b0;
    irq_mei = 1'b0;
    chk("mret_redir_v", {31'd0, redirect_valid}, 32'd1);
    chk("mret_redir_pc", redirect_pc, 32'h44);
    tick();
    chk_csr("mret_mstatus", A_MSTATUS, 32'h1888);
    tick();

    // interrupt beats a same-cycle exception
    irq_msi = 1'b1;
    tick();
    commit(32'h60, 1'b1, 4'd5, 32'h1234, 1'b0, 1'b0);
    irq_msi = 1'b0;
    chk("ie_redir_pc", redirect_pc, 32'h20C);
    tick();
    chk_csr("ie_mcause", A_MCAUSE, 32'h80000003);
    chk_csr("ie_mtval", A_MTVAL, 32'h0);
    chk_csr("ie_mepc", A_MEPC, 32'h60);
    tick();

    // wfi with MIE=0 wakes without redirect
    wr(A_MSTATUS, 32'h0);
    wr(A_MIE, 32'h80);
    commit(32'h90, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    chk("wfi0_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("wfi0_hold", {31'd0, stall}, 32'd1);
    irq_mti = 1'b1;
    n = 0;
    while (stall && n < 8) begin
      tick();
      n++;
    end
    chk("wfi0_wake_cyc", n, 2);
    chk("wfi0_redir", {31'd0, redirect_valid}, 32'd0);
    chk_csr("wfi0_mepc", A_MEPC, 32'h60);
    irq_mti = 1'b0;
    tick();
    tick();

    // wfi with MIE=1 wakes into the interrupt
    wr(A_MSTATUS, 32'h8);
    commit(32'h90, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    chk("wfi1_stall", {31'd0, stall}, 32'd1);
    irq_mti = 1'b1;
    n = 0;
    while (!redirect_valid && n < 8) begin
      tick();
      n++;
    end
    chk("wfi1_redir_v", {31'd0, redirect_valid}, 32'd1);
    chk("wfi1_redir_pc", redirect_pc, 32'h21C);
    chk("wfi1_stall_off", {31'd0, stall}, 32'd0);
    irq_mti = 1'b0;
    tick();
    chk_csr("wfi1_mepc", A_MEPC, 32'h94);
    chk_csr("wfi1_mcause", A_MCAUSE, 32'h80000007);
    chk_csr("wfi1_mstatus", A_MSTATUS, 32'h1880);
    tick();

    // write masks and address decode
    wr(A_MSTATUS, 32'hFFFF_FFFF);
    chk_csr("mask_mstatus", A_MSTATUS, 32'h1888);
    wr(A_MSTATUS, 32'h0);
    wr(A_MIE, 32'hFFFF_FFFF);
    chk_csr("mask_mie", A_MIE, 32'h888);
    wr(A_MIP, 32'hFFFF_FFFF);
    chk_csr("mask_mip", A_MIP, 32'h0);
    wr(A_MTVEC, 32'hFFFF_FFFF);
    chk_csr("mask_mtvec", A_MTVEC, 32'hFFFF_FFFD);
    chk_csr("mstatush", A_MSTATUSH, 32'h0);
    chk("mstatush_hit", {31'd0, csr_hit}, 32'd1);
    chk_csr("unlisted_rd", 12'h7C0, 32'h0);
    chk("unlisted_hit", {31'd0, csr_hit}, 32'd0);
    wr(A_MTVEC, 32'h200);

    // trap drops a same-cycle CSR write
    csr_addr  = A_MTVEC;
    csr_wdata = 32'h400;
    csr_we    = 1'b1;
    commit(32'hA0, 1'b1, 4'd7, 32'h55, 1'b0, 1'b0);
    csr_we = 1'b0;
    chk("drop_redir_pc", redirect_pc, 32'h200);
    tick();
    chk_csr("drop_mtvec", A_MTVEC, 32'h200);
    chk_csr("drop_mcause", A_MCAUSE, 32'h7);

    // reset while sleeping
    commit(32'hB0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    chk("rs_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_stall_off", {31'd0, stall}, 32'd0);
    chk("rs_redir", {31'd0, redirect_valid}, 32'd0);
    chk_csr("rs_mtvec", A_MTVEC, 32'h0);
    chk_csr("rs_mstatus", A_MSTATUS, 32'h1800);
    tick();

    // randomized trap entry against the model
    m_epc = 32'h0;
    m_cause = 32'h0;
    m_tval = 32'h0;
    for (int it = 0; it < 40; it++) begin
      w = $urandom;
      wr(A_MTVEC, w);
      m_tvec = w & 32'hFFFF_FFFD;
      w = $urandom;
      wr(A_MIE, w);
      m_ie = w & 32'h888;
      w = $urandom;
      wr(A_MSTATUS, w);
      m_mie  = w[3];
      m_mpie = w[7];
      lines = 3'($urandom_range(0, 7));
      irq_mei = lines[2];
      irq_msi = lines[1];
      irq_mti = lines[0];
      tick();
      pc   = $urandom & 32'hFFFF_FFFC;
      ex   = 1'($urandom_range(0, 1));
      code = 4'($urandom_range(0, 15));
      tv   = $urandom;
      cause = -1;
      if (m_mie) begin
        if (lines[2] && m_ie[11])     cause = 11;
        else if (lines[1] && m_ie[3]) cause = 3;
        else if (lines[0] && m_ie[7]) cause = 7;
      end
      base = {m_tvec[31:2], 2'b00};
      trapped = (cause >= 0) || ex;
      exp_pc = base;
      if (cause >= 0) begin
        if (m_tvec[1:0] == 2'd1)
          exp_pc = base + 32'(4 * cause);
        m_cause = 32'h8000_0000 | 32'(cause);
        m_tval  = 32'h0;
        m_epc   = pc;
      end else if (ex) begin
        m_cause = {28'd0, code};
        m_tval  = tv;
        m_epc   = pc;
      end
      if (trapped) begin
        m_mpie = m_mie;
        m_mie  = 1'b0;
      end
      commit(pc, ex, code, tv, 1'b0, 1'b0);
      chk("rnd_redir_v", {31'd0, redirect_valid},
          {31'd0, trapped});
      if (trapped)
        chk("rnd_redir_pc", redirect_pc, exp_pc);
      irq_mei = 1'b0;
      irq_msi = 1'b0;
      irq_mti = 1'b0;
      tick();
      chk_csr("rnd_mepc", A_MEPC, m_epc);
      chk_csr("rnd_mcause", A_MCAUSE, m_cause);
      chk_csr("rnd_mtval", A_MTVAL, m_tval);
      chk_csr("rnd_mstatus", A_MSTATUS,
              32'h1800 | (32'(m_mpie) << 7)
                       | (32'(m_mie) << 3));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
